// File: rtl/apb_xfer_ctrl.sv
// ============================================================================
// Module      : apb_xfer_ctrl
// Description : APB transfer sequencer for the AHB2APB bridge. Takes one
//               decoded request at a time, runs the APB SETUP/ACCESS phases
//               with a one-hot PSEL, and returns a single-cycle response.
//               Optional macro APB_TIMEOUT_EN adds an ACCESS wait-state
//               limit (TIMEOUT_CYCLES) that aborts the transfer with an error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_APB_SLAVES
`define NUM_APB_SLAVES 12
`endif

module apb_xfer_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLV_IDX_LSB    = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        hclk_i,
  input  logic                        hreset_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [DATA_WIDTH-1:0]       req_wdata_i,
  output logic                        rsp_valid_o,
  output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [`NUM_APB_SLAVES-1:0]  psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [ADDR_WIDTH-1:0]       paddr_o,
  output logic [DATA_WIDTH-1:0]       pwdata_o,
  input  logic                        pready_i,
  input  logic [DATA_WIDTH-1:0]       prdata_i,
  input  logic                        pslverr_i,
  output logic                        apb_busy_o
);

  localparam int NUM_SLV = `NUM_APB_SLAVES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SLV-1:0]     psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  // Slave index field; indices at or above the slave count are decode errors
  logic [3:0] idx;
  logic       idx_ok;
  assign idx    = req_addr_i[SLV_IDX_LSB+3:SLV_IDX_LSB];
  assign idx_ok = ({1'b0, idx} < 5'(NUM_SLV));

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Next-state and next-output logic; responses default to idle each cycle
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (idx_ok) begin
            state_d   = SETUP;
            psel_d    = NUM_SLV'(1) << idx;
            penable_d = 1'b0;
            pwrite_d  = req_write_i;
            paddr_d   = req_addr_i;
            pwdata_d  = req_wdata_i;
          end else begin
            // Decode error: answer directly, no APB cycle
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready_i) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_i;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This wait cycle brings the count to the limit: abort
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign apb_busy_o  = (state_q != IDLE);
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_xfer_ctrl.sv
// ============================================================================
// Module      : tb_apb_xfer_ctrl
// Description : Directed self-checking bench for apb_xfer_ctrl. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_xfer_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [11:0]   psel;
  logic          penable, pwrite, apb_busy;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  int n_checks = 0;
  int n_errors = 0;

  apb_xfer_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SLV_IDX_LSB   (12),
    .TIMEOUT_CYCLES(4)
  ) u_dut (
    .hclk_i      (clk),
    .hreset_i    (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .pready_i    (pready),
    .prdata_i    (prdata),
    .pslverr_i   (pslverr),
    .apb_busy_o  (apb_busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, landing on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    @(negedge clk);
    tick();
    // ---- reset state
    check("rst_psel", 64'(psel), 64'h0);
    check("rst_penable", 64'(penable), 64'h0);
    check("rst_pwrite", 64'(pwrite), 64'h0);
    check("rst_paddr", 64'(paddr), 64'h0);
    check("rst_pwdata", 64'(pwdata), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    check("rst_rsp_err", 64'(rsp_err), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h1);
    check("rst_busy", 64'(apb_busy), 64'h0);
    rst = 1'b0;
    tick();

    // ---- zero-wait read, idx 3
    pready = 1'b1; prdata = 32'hA5A5_0003;
    issue(1'b0, 32'h0000_3010, 32'hDEAD_BEEF);
    tick();
    req_valid = 1'b0;
    check("rd_c1_psel", 64'(psel), 64'h008);
    check("rd_c1_penable", 64'(penable), 64'h0);
    check("rd_c1_paddr", 64'(paddr), 64'h0000_3010);
    check("rd_c1_pwrite", 64'(pwrite), 64'h0);
    check("rd_c1_ready", 64'(req_ready), 64'h0);
    check("rd_c1_busy", 64'(apb_busy), 64'h1);
    tick();
    check("rd_c2_psel", 64'(psel), 64'h008);
    check("rd_c2_penable", 64'(penable), 64'h1);
    check("rd_c2_rsp_valid", 64'(rsp_valid), 64'h0);
    tick();
    check("rd_c3_rsp_valid", 64'(rsp_valid), 64'h1);
    check("rd_c3_rdata", 64'(rsp_rdata), 64'hA5A5_0003);
    check("rd_c3_err", 64'(rsp_err), 64'h0);
    check("rd_c3_psel", 64'(psel), 64'h0);
    check("rd_c3_penable", 64'(penable), 64'h0);
    check("rd_c3_ready", 64'(req_ready), 64'h1);
    tick();
    check("rd_c4_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rd_c4_rdata_hold", 64'(rsp_rdata), 64'hA5A5_0003);

    // ---- write idx 11, three wait cycles
    prdata = 32'hFFFF_FFFF;
    issue(1'b1, 32'h0000_B004, 32'h1234_5678);
    tick();
    req_valid = 1'b0; pready = 1'b0;
    check("wr_setup_psel", 64'(psel), 64'h800);
    check("wr_setup_pwrite", 64'(pwrite), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) pready = 1'b1;
      check($sformatf("wr_acc%0d_psel", i), 64'(psel), 64'h800);
      check($sformatf("wr_acc%0d_paddr", i), 64'(paddr), 64'h0000_B004);
      check($sformatf("wr_acc%0d_pwdata", i), 64'(pwdata), 64'h1234_5678);
      check($sformatf("wr_acc%0d_penable", i), 64'(penable), 64'h1);
      check($sformatf("wr_acc%0d_rsp_valid", i), 64'(rsp_valid), 64'h0);
    end
    tick();
    check("wr_rsp_valid", 64'(rsp_valid), 64'h1);
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'h0);
    check("wr_rsp_err", 64'(rsp_err), 64'h0);
    tick();

    // ---- read idx 5 with slave error
    prdata = 32'h5555_0005; pready = 1'b0; pslverr = 1'b1;
    issue(1'b0, 32'h0000_5000, 32'h0);
    tick();
    req_valid = 1'b0;
    check("err_setup_psel", 64'(psel), 64'h020);
    tick();
    check("err_wait_rsp_valid", 64'(rsp_valid), 64'h0);
    pready = 1'b1;
    tick();
    pslverr = 1'b0;
    check("err_rsp_valid", 64'(rsp_valid), 64'h1);
    check("err_rsp_err", 64'(rsp_err), 64'h1);
    check("err_rsp_rdata", 64'(rsp_rdata), 64'h5555_0005);
    tick();
    check("err_after_err", 64'(rsp_err), 64'h0);

    // ---- decode error idx 12
    issue(1'b0, 32'h0000_C000, 32'h0);
    tick();
    req_valid = 1'b0;
    check("dec_psel", 64'(psel), 64'h0);
    check("dec_ready", 64'(req_ready), 64'h1);
    check("dec_busy", 64'(apb_busy), 64'h0);
    check("dec_rsp_valid", 64'(rsp_valid), 64'h1);
    check("dec_rsp_err", 64'(rsp_err), 64'h1);
    check("dec_rsp_rdata", 64'(rsp_rdata), 64'h0);
    tick();
    check("dec_after_valid", 64'(rsp_valid), 64'h0);
    check("dec_after_err", 64'(rsp_err), 64'h0);

    // ---- back-to-back idx 0 then idx 1, req_valid held
    pready = 1'b1; prdata = 32'h0000_00A0;
    issue(1'b0, 32'h0000_0000, 32'h0);
    tick();
    req_addr = 32'h0000_1000;  // late change must not affect the first transfer
    check("b2b_setup0_psel", 64'(psel), 64'h001);
    tick();
    check("b2b_acc0_psel", 64'(psel), 64'h001);
    check("b2b_acc0_paddr", 64'(paddr), 64'h0000_0000);
    tick();
    check("b2b_rsp0_valid", 64'(rsp_valid), 64'h1);
    check("b2b_rsp0_ready", 64'(req_ready), 64'h1);
    check("b2b_gap_psel", 64'(psel), 64'h0);
    tick();
    req_valid = 1'b0;
    check("b2b_setup1_psel", 64'(psel), 64'h002);
    check("b2b_setup1_rsp_valid", 64'(rsp_valid), 64'h0);
    check("b2b_setup1_paddr", 64'(paddr), 64'h0000_1000);
    tick();
    tick();
    check("b2b_rsp1_valid", 64'(rsp_valid), 64'h1);
    check("b2b_rsp1_rdata", 64'(rsp_rdata), 64'h0000_00A0);
    tick();

    // ---- reset during second ACCESS wait cycle
    pready = 1'b0;
    issue(1'b1, 32'h0000_2008, 32'hCAFE_F00D);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("rstx_in_access", 64'(penable), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; pready = 1'b1;
    check("rstx_psel", 64'(psel), 64'h0);
    check("rstx_penable", 64'(penable), 64'h0);
    check("rstx_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rstx_ready", 64'(req_ready), 64'h1);
    tick();
    check("rstx_after_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rstx_after_busy", 64'(apb_busy), 64'h0);

    // ---- wait-state limit (or its absence)
    pready = 1'b0; prdata = 32'h7777_7777;
    issue(1'b0, 32'h0000_4000, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_wait%0d_psel", i), 64'(psel), 64'h010);
      check($sformatf("to_wait%0d_rsp_valid", i), 64'(rsp_valid), 64'h0);
    end
    tick();
`ifdef APB_TIMEOUT_EN
    check("to_abort_valid", 64'(rsp_valid), 64'h1);
    check("to_abort_err", 64'(rsp_err), 64'h1);
    check("to_abort_rdata", 64'(rsp_rdata), 64'h0);
    check("to_abort_psel", 64'(psel), 64'h0);
    check("to_abort_penable", 64'(penable), 64'h0);
`else
    check("to_still_waiting", 64'(apb_busy), 64'h1);
    check("to_no_rsp", 64'(rsp_valid), 64'h0);
    check("to_psel_held", 64'(psel), 64'h010);
    pready = 1'b1;
    tick();
    check("to_late_valid", 64'(rsp_valid), 64'h1);
    check("to_late_rdata", 64'(rsp_rdata), 64'h7777_7777);
    check("to_late_err", 64'(rsp_err), 64'h0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_xfer_ctrl.md
Name: apb_xfer_ctrl

Overview:
APB transfer sequencer for the AHB2APB bridge. Accepts one decoded request at a time from the AHB-side front end and drives the APB master signals through the SETUP and ACCESS phases. Drives a one-hot PSEL to the slaves; that same vector is the select for the per-signal response muxes (PRDATA, PREADY, PSLVERR). Returns a single-cycle response with read data and error status.

Parameters:
ADDR_WIDTH, 32, width of req_addr and paddr
DATA_WIDTH, 32, width of write and read data
SLV_IDX_LSB, 12, LSB of the 4-bit slave index field in req_addr (4 KB per slave)
TIMEOUT_CYCLES, 255, ACCESS wait-state limit; used only with APB_TIMEOUT_EN

Ports:
hclk  in  1  clock
hreset  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  slave error, decode error or timeout
psel  out  `NUM_APB_SLAVES (12)  one-hot slave select; also the response-mux select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  muxed PREADY of the selected slave (0 when psel == 0)
prdata  in  DATA_WIDTH  muxed PRDATA
pslverr  in  1  muxed PSLVERR
apb_busy  out  1  high in SETUP or ACCESS

Behaviour:
- Reset (hreset high at a hclk edge) drives state to IDLE. Reset values: psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. A reset during SETUP or ACCESS abandons the transfer and produces no rsp_valid.
- All outputs are registered. req_ready = (state == IDLE), so it is high in IDLE and low otherwise.
- Decode: idx = req_addr[SLV_IDX_LSB+3:SLV_IDX_LSB]. The request is valid when idx < 12.
- IDLE:
  - If req_valid is high and idx is valid, go to SETUP. On that edge, register psel = 1 << idx, paddr, pwrite and pwdata; penable = 0.
  - If req_valid is high and idx >= 12, stay in IDLE. On the next cycle pulse rsp_valid = 1 with rsp_err = 1 and rsp_rdata = 0. No APB activity occurs.
- SETUP: lasts exactly one cycle, then goes to ACCESS with penable = 1.
- ACCESS:
  - psel, paddr, pwrite and pwdata hold stable.
  - While pready = 0, stay in ACCESS.
  - When pready = 1, go to IDLE. In the next cycle, psel = 0 and penable = 0, and rsp_valid = 1 for one cycle.
  - rsp_err = pslverr. rsp_rdata = prdata on reads; rsp_rdata = 0 on writes.
- Latency:
  - Zero-wait transfer: request accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
  - Each cycle with pready = 0 in ACCESS adds one cycle.
- Back-to-back: req_ready is high in the same cycle that rsp_valid is high. A new request accepted then starts SETUP in the next cycle, so psel is low for exactly one cycle between transfers.
- Request fields are sampled only at acceptance. Changes to req_* after acceptance are ignored.
- rsp_rdata holds its last value when rsp_valid = 0. rsp_err is 0 whenever rsp_valid = 0.
- psel is always one-hot or zero. It is never nonzero in IDLE.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT_CYCLES with pready still 0, the transfer is aborted: go to IDLE, deassert psel and penable, then pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0.
  - pready = 1 on the same cycle the limit is reached counts as a normal completion.
- Undefined: no counter is built, and ACCESS waits for pready indefinitely.

Test Plan:
- Zero-wait read, req_addr = 0x0000_3010 (idx 3), prdata = 0xA5A5_0003, pready tied high -> psel = 12'h008 in cycles 1-2, penable high in cycle 2 only, rsp_valid in cycle 3 with rsp_rdata = 0xA5A5_0003 and rsp_err = 0.
- Write to idx 11 (addr 0x0000_B004, wdata 0x1234_5678) with pready low for 3 ACCESS cycles -> paddr, pwdata and psel = 12'h800 stable for 4 ACCESS cycles, rsp_valid 1 cycle after pready, rsp_rdata = 0.
- Read of idx 5 with pslverr = 1 on the completing cycle -> rsp_err = 1 with rsp_valid; pslverr = 1 while pready = 0 is ignored.
- Decode error, addr 0x0000_C000 (idx 12) -> psel stays 0, rsp_valid next cycle with rsp_err = 1, req_ready stays high.
- Back-to-back requests to idx 0 then idx 1, req_valid held high -> second SETUP starts the cycle after the first rsp_valid, psel 12'h001 -> 0 for one cycle -> 12'h002.
- hreset asserted in the 2nd ACCESS wait cycle -> next cycle psel = 0, penable = 0, no rsp_valid, req_ready = 1. With APB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, pready held low -> abort after 4 wait cycles with rsp_err = 1.
